// File: rtl/led_7seg_pkg.sv
// Shared segment bit positions and the hex font for the 7-segment scan driver.
// Output byte layout: bit7=A ... bit1=G, bit0=DP.
package led_7seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] MA = 8'h01 << SEG_A;
  localparam logic [7:0] MB = 8'h01 << SEG_B;
  localparam logic [7:0] MC = 8'h01 << SEG_C;
  localparam logic [7:0] MD = 8'h01 << SEG_D;
  localparam logic [7:0] ME = 8'h01 << SEG_E;
  localparam logic [7:0] MF = 8'h01 << SEG_F;
  localparam logic [7:0] MG = 8'h01 << SEG_G;

  // Active-high ABCDEFG pattern; b and d lowercase, 6 and 9 drawn with tails.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [7:0] f;
    f = '0;
    case (nib)
      4'h0: f = MA | MB | MC | MD | ME | MF;
      4'h1: f = MB | MC;
      4'h2: f = MA | MB | MD | ME | MG;
      4'h3: f = MA | MB | MC | MD | MG;
      4'h4: f = MB | MC | MF | MG;
      4'h5: f = MA | MC | MD | MF | MG;
      4'h6: f = MA | MC | MD | ME | MF | MG;
      4'h7: f = MA | MB | MC;
      4'h8: f = MA | MB | MC | MD | ME | MF | MG;
      4'h9: f = MA | MB | MC | MD | MF | MG;
      4'hA: f = MA | MB | MC | ME | MF | MG;
      4'hB: f = MC | MD | ME | MF | MG;
      4'hC: f = MA | MD | ME | MF;
      4'hD: f = MB | MC | MD | ME | MG;
      4'hE: f = MA | MD | ME | MF | MG;
      4'hF: f = MA | ME | MF | MG;
      default: f = '0;
    endcase
    return f[SEG_A:SEG_G];
  endfunction

endpackage

// File: rtl/led_7seg_font.sv
// Combinational nibble to active-high ABCDEFG segment pattern.
module led_7seg_font
  import led_7seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_font(nib_i);

endmodule

// File: rtl/led_7seg_scan.sv
// N-digit time-multiplexed 7-segment driver with frame-synchronous loads,
// leading-zero suppression, per-digit DP/blank and anti-ghost blanking.
module led_7seg_scan
  import led_7seg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int CLK_HZ      = 20_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int BLANK_CYC   = 4,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_suppress,
  output logic                  upd_pending,
  output logic                  frame_start,
  output logic [7:0]            seg_ABCDEFG_DP,
  output logic [N_DIGITS-1:0]   digit_sel
);

  localparam int TICK_DIV = CLK_HZ / (REFRESH_HZ * N_DIGITS);
  localparam int SLOT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(TICK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LIT  = SLOT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACT_LOW != 0);
  localparam logic AN_INV  = (AN_ACT_LOW != 0);

  generate
    if (TICK_DIV < BLANK_CYC + 2) begin : g_bad_tick_div
      $error("led_7seg_scan: TICK_DIV must be >= BLANK_CYC+2");
    end
  endgenerate

  typedef struct packed {
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
  } disp_t;

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                frame_start_q, frame_start_d;
  logic                upd_q, upd_d;
  disp_t               pend_q, pend_d;
  disp_t               act_q, act_d;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] sel_q, sel_d;

  logic                slot_wrap;
  logic [N_DIGITS-1:0] keep;
  logic                seen;
  logic [3:0]          nib;
  logic                dp_bit, blank_bit, keep_bit, lit;
  logic [6:0]          font_seg;
  logic [7:0]          raw;

  // Scan counters; frame_start is registered so it is high while both are 0.
  always_comb begin
    slot_wrap     = (slot_q == SLOT_LAST);
    slot_d        = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d         = idx_q;
    if (slot_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    frame_start_d = slot_wrap && (idx_q == IDX_LAST);
  end

  // The frame_start cycle is the boundary: pending moves to active on its
  // closing edge, while a load in that same cycle stays pending for a frame.
  always_comb begin
    act_d  = (frame_start_q && upd_q) ? pend_q : act_q;
    pend_d = load ? disp_t'{value: value, dp: dp_in, blank: blank_in} : pend_q;
    upd_d  = load | (upd_q & ~frame_start_q);
  end

  // Pattern is computed from act_d so the digit-0 slot never shows stale data.
  always_comb begin
    seen = 1'b0;
    keep = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (act_d.value[4*i +: 4] != 4'h0) seen = 1'b1;
      keep[i] = seen | ~lz_suppress | (i == 0);
    end
    nib       = '0;
    dp_bit    = 1'b0;
    blank_bit = 1'b0;
    keep_bit  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib       = act_d.value[4*i +: 4];
        dp_bit    = act_d.dp[i];
        blank_bit = act_d.blank[i];
        keep_bit  = keep[i];
      end
    end
  end

  led_7seg_font u_font (
    .nib_i (nib),
    .seg_o (font_seg)
  );

  always_comb begin
    raw         = '0;
    raw[SEG_DP] = dp_bit;
    if (keep_bit) raw[SEG_A:SEG_G] = font_seg;
    if (blank_bit) raw = '0;
    lit   = (slot_q >= SLOT_LIT);
    seg_d = (lit ? raw : 8'h00) ^ {8{SEG_INV}};
    sel_d = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      sel_d[i] = lit && (idx_q == IDX_W'(i));
    end
    sel_d = sel_d ^ {N_DIGITS{AN_INV}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= '0;
      idx_q         <= '0;
      frame_start_q <= 1'b0;
      upd_q         <= 1'b0;
      pend_q        <= '0;
      act_q         <= '0;
      seg_q         <= {8{SEG_INV}};
      sel_q         <= {N_DIGITS{AN_INV}};
    end else begin
      slot_q        <= slot_d;
      idx_q         <= idx_d;
      frame_start_q <= frame_start_d;
      upd_q         <= upd_d;
      pend_q        <= pend_d;
      act_q         <= act_d;
      seg_q         <= seg_d;
      sel_q         <= sel_d;
    end
  end

  assign upd_pending    = upd_q;
  assign frame_start    = frame_start_q;
  assign seg_ABCDEFG_DP = seg_q;
  assign digit_sel      = sel_q;

endmodule

// File: tb/tb_led_7seg_scan.sv
// Bench for led_7seg_scan: frame-level reference model feeds an expected queue of
// per-slot {digit_sel, seg} words; a negedge monitor pops and compares each lit slot.
module tb_led_7seg_scan;

  localparam int N      = 4;
  localparam int TICK   = 8;
  localparam int FRAME  = TICK * N;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } load_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_suppress = 1'b0;
  logic        upd_pending, frame_start;
  logic [7:0]  seg;
  logic [3:0]  digit_sel;

  led_7seg_scan #(
    .N_DIGITS(N), .CLK_HZ(16000), .REFRESH_HZ(500), .BLANK_CYC(2),
    .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .lz_suppress(lz_suppress), .upd_pending(upd_pending),
    .frame_start(frame_start), .seg_ABCDEFG_DP(seg), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  // Reference model state (frame granularity).
  load_t ref_act = '0;
  load_t ref_pend = '0;
  logic  ref_upd = 1'b0;

  // Segment shapes by letter, standard hex font.
  string font_s [16] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG", "ACDEFG", "ABC",
                         "ABCDEFG", "ABCDFG", "ABCEFG", "CDEFG", "ADEF", "BCDEG", "ADEFG", "AEFG"};

  function automatic logic [7:0] pattern(input logic [3:0] nib, input logic dp, input logic show);
    logic [7:0] on = '0;
    string s = font_s[nib];
    if (show) begin
      for (int k = 0; k < s.len(); k++) on[7 - int'(s.getc(k) - 8'd65)] = 1'b1;
    end
    on[0] = dp;
    return ~on;
  endfunction

  function automatic logic [11:0] exp_slot(input load_t a, input logic lz, input int i);
    int top = -1;
    logic [3:0] sel;
    logic [7:0] s;
    for (int j = 0; j < N; j++) if (a.value[4*j +: 4] != 4'h0) top = j;
    sel = ~(4'b0001 << i);
    if (a.blank[i]) s = 8'hFF;
    else s = pattern(a.value[4*i +: 4], a.dp[i], !(lz && i > 0 && i > top));
    return {sel, s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) exp_q.push_back(exp_slot(ref_act, lz_suppress, i));
  endtask

  // Monitor: each lit slot pops one expectation; dark cycles must be fully off.
  logic        prev_lit = 1'b0;
  logic        first_slot = 1'b1;
  int          dark_run = 0;
  logic [11:0] cur = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_lit = 1'b0;
      first_slot = 1'b1;
      dark_run = 0;
    end else if (digit_sel == 4'hF) begin
      check("dark_seg", 32'(seg), 32'h0FF);
      dark_run++;
      prev_lit = 1'b0;
    end else begin
      if (!prev_lit) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL underflow: lit slot sel=%0h seg=%0h with no expectation at %0t", digit_sel, seg, $time);
          cur = {digit_sel, seg};
        end else begin
          cur = exp_q.pop_front();
          check("slot", 32'({digit_sel, seg}), 32'(cur));
        end
        if (!first_slot) check("blank_len", 32'(dark_run), 32'd2);
        first_slot = 1'b0;
      end else begin
        check("hold", 32'({digit_sel, seg}), 32'(cur));
      end
      dark_run = 0;
      prev_lit = 1'b1;
    end
  end

  task automatic wait_fs();
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (frame_start) return;
      @(posedge clk); #1;
    end
    $display("FAIL frame_start_timeout: no frame_start within %0d cycles", 2 * FRAME);
    $fatal(1, "frame sync lost");
  endtask

  // Returns positioned just after the edge that raises the first frame_start.
  task automatic do_reset();
    int found = 0;
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_seg", 32'(seg), 32'h0FF);
    check("rst_sel", 32'(digit_sel), 32'hF);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_upd", 32'(upd_pending), 32'd0);
    ref_act = '0;
    ref_pend = '0;
    ref_upd = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push_frame();
    for (int c = 1; c <= FRAME + 8; c++) begin
      @(posedge clk); #1;
      if (frame_start) begin
        found = c;
        break;
      end
    end
    check("first_frame_start", 32'(found), 32'(FRAME));
    if (found == 0) wait_fs();
  endtask

  task automatic drive(input load_t d);
    load = 1'b1;
    value = d.value;
    dp_in = d.dp;
    blank_in = d.blank;
    ref_pend = d;
    ref_upd = 1'b1;
  endtask

  // Entered in the frame_start cycle; offsets are cycles from that cycle.
  task automatic run_frame(input int off1, input load_t d1, input int off2, input load_t d2,
                           input logic lz, input int abort_at);
    check("upd_at_boundary", 32'(upd_pending), 32'(ref_upd));
    if (ref_upd) begin
      ref_act = ref_pend;
      ref_upd = 1'b0;
    end
    lz_suppress = lz;
    push_frame();
    for (int o = 0; o < FRAME; o++) begin
      if (o == abort_at) begin
        do_reset();
        return;
      end
      if (o > 0) begin
        check("fs_low", 32'(frame_start), 32'd0);
        check("upd_pending", 32'(upd_pending), 32'(ref_upd));
      end
      if (o == off1) drive(d1);
      else if (o == off2) drive(d2);
      else load = 1'b0;
      @(posedge clk); #1;
    end
    load = 1'b0;
    check("frame_start", 32'(frame_start), 32'd1);
    if (!frame_start) wait_fs();
  endtask

  function automatic load_t rand_load();
    load_t d;
    logic [15:0] m = 16'hFFFF;
    m = m >> (4 * $urandom_range(0, 4));
    d.value = 16'($urandom) & m;
    d.dp = 4'($urandom);
    d.blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    return d;
  endfunction

  initial begin
    load_t z = '0;
    do_reset();
    run_frame(-1, z, -1, z, 1'b0, -1);
    run_frame(5, '{16'h12AF, 4'h0, 4'h0}, -1, z, 1'b0, -1);
    run_frame(-1, z, -1, z, 1'b0, -1);
    run_frame(7, '{16'h0050, 4'b1000, 4'h0}, -1, z, 1'b1, -1);
    run_frame(-1, z, -1, z, 1'b1, -1);
    run_frame(3, '{16'h1111, 4'h0, 4'h0}, 20, '{16'h2222, 4'h0, 4'h0}, 1'b0, -1);
    run_frame(-1, z, -1, z, 1'b0, -1);
    run_frame(0, '{16'h4321, 4'h0, 4'h0}, -1, z, 1'b0, -1);
    run_frame(-1, z, -1, z, 1'b0, -1);
    run_frame(9, '{16'h9876, 4'b0010, 4'b0010}, -1, z, 1'b0, -1);
    run_frame(-1, z, -1, z, 1'b0, -1);
    run_frame(4, '{16'h7777, 4'hF, 4'h0}, -1, z, 1'b0, 13);
    run_frame(-1, z, -1, z, 1'b1, -1);
    for (int f = 0; f < 30; f++) begin
      int mode = $urandom_range(0, 3);
      logic lz = 1'($urandom);
      load_t d1 = rand_load();
      load_t d2 = rand_load();
      case (mode)
        0: run_frame(-1, d1, -1, d2, lz, -1);
        1: run_frame($urandom_range(0, FRAME - 1), d1, -1, d2, lz, -1);
        2: run_frame($urandom_range(0, 15), d1, $urandom_range(16, FRAME - 1), d2, lz, -1);
        default: run_frame(0, d1, -1, d2, lz, -1);
      endcase
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
